memory_access: RTL and testbench

- MEM stage of the 5-stage pipeline, directly downstream of execute.
- Consumes the ALU result as the address, the rs2 data as store data, and the destination register.
- Runs loads/stores against a req/ack data-memory port, aligns and sign-extends load data, and generates byte enables.
- Stalls upstream while an access is outstanding, then presents registered results to writeback.

---
 rtl/memory_access_if.sv | 21 ++
 rtl/memory_access.sv | 241 ++++++++++++++++++++++++
 tb/tb_memory_access.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge port shared by the MEM stage and the data memory.
// The master is the pipeline stage; the slave is the memory.
interface memory_access_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_rdata_i, dmem_ack_i
    );
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: issues loads/stores on a req/ack port, aligns load data,
// builds byte lanes, stalls upstream while an access is outstanding.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic [31:0] instruction_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data2_i,
    input  logic [4:0]  write_addr_reg_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        reg_write_i,
    memory_access_if.master dmem,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_reg_write_o,
    output logic        wb_valid_o,
    output logic        misaligned_o,
    output logic        bus_error_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic                 we_q, we_d;
    logic [4:0]           rd_q, rd_d;
    logic [2:0]           f3_q, f3_d;
    logic                 rw_q, rw_d;

    logic [31:0]          wb_data_q, wb_data_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic                 wb_rw_q, wb_rw_d;
    logic                 wb_valid_q, wb_valid_d;
    logic                 mis_q, mis_d;
    logic                 berr_q, berr_d;
    logic                 stall;

    logic [2:0]           funct3;
    logic                 is_mem;
    logic                 is_store;
    logic                 legal;
    logic                 misaligned;
    logic [3:0]           st_be;
    logic [31:0]          st_wdata;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_data;

    logic                 unused_instr;
    assign unused_instr = ^{instruction_i[31:15], instruction_i[11:0]};

    // Decode and alignment checks for the instruction offered by execute.
    always_comb begin
        funct3   = instruction_i[14:12];
        is_mem   = valid_i & (mem_read_i | mem_write_i);
        is_store = mem_write_i;
        if (is_store) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        misaligned = legal &&
                     (((funct3[1:0] == 2'b01) && alu_result_i[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00)));
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = read_data2_i;
        unique case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_result_i[1:0];
                st_wdata = {4{read_data2_i[7:0]}};
            end
            2'b01: begin
                st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{read_data2_i[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = read_data2_i;
            end
        endcase
    end

    // Lane select uses the latched address, since execute has moved on by ack time.
    always_comb begin
        ld_byte = dmem.dmem_rdata_i[7:0];
        unique case (addr_q[1:0])
            2'b00: ld_byte = dmem.dmem_rdata_i[7:0];
            2'b01: ld_byte = dmem.dmem_rdata_i[15:8];
            2'b10: ld_byte = dmem.dmem_rdata_i[23:16];
            2'b11: ld_byte = dmem.dmem_rdata_i[31:24];
            default: ld_byte = dmem.dmem_rdata_i[7:0];
        endcase
        ld_half = addr_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = dmem.dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        rw_d       = rw_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = 1'b0;
        wb_valid_d = 1'b0;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        stall      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                wb_data_d = alu_result_i;
                wb_rd_d   = write_addr_reg_i;
                if (!valid_i) begin
                    wb_valid_d = 1'b0;
                end else if (!is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = reg_write_i;
                end else if (!legal) begin
                    wb_valid_d = 1'b1;
                end else if (misaligned) begin
                    wb_valid_d = 1'b1;
                    mis_d      = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    addr_d  = alu_result_i;
                    wdata_d = st_wdata;
                    be_d    = is_store ? st_be : 4'b1111;
                    we_d    = is_store;
                    rd_d    = write_addr_reg_i;
                    f3_d    = funct3;
                    rw_d    = reg_write_i & ~is_store;
                end
            end
            S_WAIT: begin
                wb_rd_d = rd_q;
                if (dmem.dmem_ack_i) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = rw_q;
                    wb_data_d  = we_q ? addr_q : ld_data;
                end else if (cnt_q == CNT_LIMIT) begin
                    // Stall is released in this cycle so upstream does not re-offer the access.
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    berr_d     = 1'b1;
                end else begin
                    stall = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            f3_q       <= '0;
            rw_q       <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            rw_q       <= rw_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_valid_q <= wb_valid_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign dmem.dmem_req_o   = (state_q == S_WAIT);
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_wdata_o = wdata_q;
    assign dmem.dmem_be_o    = be_q;

    assign stall_o        = stall & ~reset_i;
    assign wb_data_o      = wb_data_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_reg_write_o = wb_rw_q;
    assign wb_valid_o     = wb_valid_q;
    assign misaligned_o   = mis_q;
    assign bus_error_o    = berr_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a transaction-level model predicts every
// cycle's outputs; a few literal checks pin the model.
module tb_memory_access;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_valid;
    logic        misaligned;
    logic        bus_error;

    memory_access_if bus();

    memory_access #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .valid_i          (valid),
        .instruction_i    (instr),
        .alu_result_i     (alu),
        .read_data2_i     (rs2),
        .write_addr_reg_i (rd_in),
        .mem_read_i       (mem_read),
        .mem_write_i      (mem_write),
        .reg_write_i      (reg_write),
        .dmem             (bus),
        .stall_o          (stall),
        .wb_data_o        (wb_data),
        .wb_rd_o          (wb_rd),
        .wb_reg_write_o   (wb_reg_write),
        .wb_valid_o       (wb_valid),
        .misaligned_o     (misaligned),
        .bus_error_o      (bus_error)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int stall_cnt  = 0;
    int req_cnt    = 0;
    bit checking   = 0;

    // Expected outputs for the current cycle, and for the cycle after the next edge.
    bit          exp_stall, skip_stall, exp_zero, exp_valid, exp_rw, exp_mis, exp_berr, exp_req, exp_we, exp_chk;
    bit [4:0]    exp_rd;
    bit [31:0]   exp_data, exp_addr, exp_wdata;
    bit [3:0]    exp_be;
    bit          nxt_zero, nxt_valid, nxt_rw, nxt_mis, nxt_berr, nxt_req, nxt_we, nxt_chk;
    bit [4:0]    nxt_rd;
    bit [31:0]   nxt_data, nxt_addr, nxt_wdata;
    bit [3:0]    nxt_be;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input bit [2:0] f3);
        return (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    endfunction

    function automatic bit f_legal(input bit st, input bit [2:0] f3);
        if (st) return f3 <= 2;
        return (f3 <= 2) || (f3 == 4) || (f3 == 5);
    endfunction

    function automatic bit f_misal(input bit [2:0] f3, input bit [31:0] a);
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic bit [3:0] f_be(input bit st, input bit [2:0] f3, input bit [31:0] a);
        if (!st) return 4'd15;
        if (size_of(f3) == 1) return 4'(1 << (a % 4));
        if (size_of(f3) == 2) return (a % 4 >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic bit [31:0] f_wdata(input bit [2:0] f3, input bit [31:0] d);
        if (size_of(f3) == 1) return (d % 256) * 32'h0101_0101;
        if (size_of(f3) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit [31:0] f_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] r);
        bit [31:0] mask, v;
        if (size_of(f3) == 4) return r;
        mask = (size_of(f3) == 1) ? 32'd255 : 32'd65535;
        v = (r >> ((a % 4) * 8)) & mask;
        if (f3 < 4 && v > (mask >> 1)) v = v - (mask + 1);
        return v;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (checking) begin
                if (!skip_stall) chk("stall", stall, exp_stall);
                chk("dmem_req", bus.dmem_req_o, exp_req);
                chk("wb_valid", wb_valid, exp_valid);
                chk("wb_reg_write", wb_reg_write, exp_rw);
                chk("misaligned", misaligned, exp_mis);
                chk("bus_error", bus_error, exp_berr);
                if (exp_valid) chk("wb_rd", wb_rd, exp_rd);
                if (exp_chk) chk("wb_data", wb_data, exp_data);
                if (exp_req) begin
                    chk("dmem_we", bus.dmem_we_o, exp_we);
                    chk("dmem_addr", bus.dmem_addr_o, exp_addr);
                    chk("dmem_be", bus.dmem_be_o, exp_be);
                    chk("dmem_wdata", bus.dmem_wdata_o, exp_wdata);
                end
                if (exp_zero) begin
                    chk("rst_wb_data", wb_data, 0);
                    chk("rst_wb_rd", wb_rd, 0);
                    chk("rst_dmem_we", bus.dmem_we_o, 0);
                    chk("rst_dmem_addr", bus.dmem_addr_o, 0);
                    chk("rst_dmem_be", bus.dmem_be_o, 0);
                    chk("rst_dmem_wdata", bus.dmem_wdata_o, 0);
                end
                if (stall === 1'b1) stall_cnt++;
                if (bus.dmem_req_o === 1'b1) begin
                    req_cnt++;
                    cap_be    = bus.dmem_be_o;
                    cap_wdata = bus.dmem_wdata_o;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_zero = nxt_zero; exp_valid = nxt_valid; exp_rw = nxt_rw; exp_mis = nxt_mis;
        exp_berr = nxt_berr; exp_req = nxt_req; exp_we = nxt_we; exp_chk = nxt_chk;
        exp_rd = nxt_rd; exp_data = nxt_data; exp_addr = nxt_addr; exp_be = nxt_be;
        exp_wdata = nxt_wdata;
        nxt_zero = 0; nxt_valid = 0; nxt_rw = 0; nxt_mis = 0; nxt_berr = 0;
        nxt_req = 0; nxt_chk = 0;
        exp_stall = 0; skip_stall = 0;
    endtask

    task automatic drive_idle();
        valid = 0; mem_read = 0; mem_write = 0; reg_write = 0;
        exp_stall = 0;
    endtask

    task automatic run_op(input bit v, input bit mr, input bit mw, input bit [2:0] f3,
                          input bit [31:0] a, input bit [31:0] wd, input bit [4:0] rd,
                          input bit rw, input int ack_at, input bit [31:0] rdata);
        valid = v; mem_read = mr; mem_write = mw; reg_write = rw;
        instr = {17'h0, f3, 12'h003}; alu = a; rs2 = wd; rd_in = rd;
        nxt_rd = rd;
        if (!v) begin
            exp_stall = 0;
            tick();
        end else if (!(mr || mw)) begin
            exp_stall = 0; nxt_valid = 1; nxt_rw = rw; nxt_data = a; nxt_chk = 1;
            tick();
        end else if (!f_legal(mw, f3) || f_misal(f3, a)) begin
            exp_stall = 0; nxt_valid = 1; nxt_mis = f_legal(mw, f3);
            tick();
        end else begin
            exp_stall = 1; nxt_req = 1; nxt_we = mw; nxt_addr = a - (a % 4);
            nxt_be = f_be(mw, f3, a); nxt_wdata = mw ? f_wdata(f3, wd) : wd;
            tick();
            for (int w = 0; w < TO; w++) begin
                if (w == ack_at) begin
                    bus.dmem_ack_i = 1; bus.dmem_rdata_i = rdata;
                    exp_stall = 0; nxt_valid = 1; nxt_rw = !mw && rw;
                    nxt_chk = !mw; nxt_data = f_load(f3, a, rdata);
                    tick();
                    bus.dmem_ack_i = 0;
                    break;
                end else if (w == TO - 1) begin
                    exp_stall = 0; nxt_valid = 1; nxt_berr = 1;
                    tick();
                    break;
                end else begin
                    exp_stall = 1; nxt_req = 1;
                    tick();
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        reset = 1; bus.dmem_ack_i = 0; bus.dmem_rdata_i = 0;
        instr = 0; alu = 0; rs2 = 0; rd_in = 0;
        drive_idle();
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        exp_zero = 1; exp_valid = 0; exp_rw = 0; exp_mis = 0; exp_berr = 0;
        exp_req = 0; exp_chk = 0; exp_stall = 0;
        checking = 1;
        reset = 0;
        tick();

        // Non-memory op passes ALU result straight through.
        run_op(1, 0, 0, 3'b000, 32'h1234, 0, 5'd5, 1, -1, 0);
        chk("lit_nonmem_data", wb_data, 32'h0000_1234);
        chk("lit_nonmem_rd", wb_rd, 5);

        // LB at 0x103 with two wait cycles.
        stall_cnt = 0;
        run_op(1, 1, 0, 3'b000, 32'h103, 0, 5'd7, 1, 2, 32'h80FF_FF00);
        chk("lit_lb_data", wb_data, 32'hFFFF_FF80);
        chk("lit_lb_stall_cycles", stall_cnt, 3);

        // SH at 0x202 lands in the upper half.
        run_op(1, 0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd9, 1, 0, 0);
        chk("lit_sh_be", cap_be, 4'b1100);
        chk("lit_sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("lit_sh_rw", wb_reg_write, 0);

        // Misaligned LW never reaches the bus.
        req_cnt = 0;
        run_op(1, 1, 0, 3'b010, 32'h6, 0, 5'd3, 1, 0, 0);
        chk("lit_misal_flag", misaligned, 1);
        chk("lit_misal_req_cnt", req_cnt, 0);

        run_op(1, 1, 0, 3'b001, 32'h302, 0, 5'd4, 1, 1, 32'h8001_7FFF);
        chk("lit_lh_data", wb_data, 32'hFFFF_8001);
        run_op(1, 1, 0, 3'b101, 32'h300, 0, 5'd4, 1, 0, 32'h8001_F00F);
        run_op(1, 1, 0, 3'b100, 32'h101, 0, 5'd6, 1, 0, 32'h0000_A500);
        chk("lit_lbu_data", wb_data, 32'h0000_00A5);
        run_op(1, 1, 0, 3'b000, 32'h100, 0, 5'd6, 1, 1, 32'h0000_007F);
        run_op(1, 1, 0, 3'b010, 32'h404, 0, 5'd8, 1, 0, 32'hDEAD_BEEF);
        run_op(1, 0, 1, 3'b000, 32'h403, 32'h1122_3344, 5'd1, 1, 0, 0);
        chk("lit_sb_be", cap_be, 4'b1000);
        chk("lit_sb_wdata", cap_wdata, 32'h4444_4444);
        run_op(1, 0, 1, 3'b010, 32'h500, 32'hCAFE_F00D, 5'd1, 0, 1, 0);
        run_op(1, 0, 1, 3'b001, 32'h201, 32'h1, 5'd2, 0, 0, 0);
        run_op(1, 1, 0, 3'b011, 32'h600, 0, 5'd2, 1, 0, 0);
        run_op(1, 0, 1, 3'b100, 32'h600, 0, 5'd2, 1, 0, 0);
        run_op(0, 0, 0, 3'b000, 32'h77, 0, 5'd2, 1, -1, 0);
        run_op(1, 0, 0, 3'b000, 32'h55, 0, 5'd0, 1, -1, 0);

        // Timeout, then an ack on the very last allowed cycle.
        req_cnt = 0;
        run_op(1, 1, 0, 3'b010, 32'h80, 0, 5'd10, 1, -1, 0);
        chk("lit_to_req_cycles", req_cnt, TO);
        chk("lit_to_bus_error", bus_error, 1);
        run_op(1, 1, 0, 3'b010, 32'h84, 0, 5'd11, 1, TO - 1, 32'h1234_5678);
        chk("lit_late_ack_data", wb_data, 32'h1234_5678);
        chk("lit_late_ack_berr", bus_error, 0);

        // Reset during WAIT, followed by a stray ack.
        valid = 1; mem_read = 1; mem_write = 0; reg_write = 1;
        instr = {17'h0, 3'b010, 12'h003}; alu = 32'h40; rd_in = 5'd12;
        exp_stall = 1; nxt_req = 1; nxt_we = 0; nxt_addr = 32'h40; nxt_be = 4'hF; nxt_wdata = rs2;
        tick();
        reset = 1; skip_stall = 1; nxt_zero = 1;
        tick();
        reset = 0; drive_idle();
        bus.dmem_ack_i = 1; bus.dmem_rdata_i = 32'hFFFF_FFFF;
        tick();
        bus.dmem_ack_i = 0;
        chk("lit_stray_ack_valid", wb_valid, 0);
        tick();
        tick();

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
